muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle M-extension execute unit that sits directly upstream of the combinational 32-bit low-product multiplier (mul_unit).
- Captures operands from the EX stage with a valid/ready handshake and registers them into mul_unit.
- Also runs a radix-2 restoring divider for DIV/DIVU/REM/REMU.
- Returns a tagged result to writeback over a second valid/ready handshake; the pipeline stalls on in_ready low.

Parameters:
- XLEN, 32, operand/result width (fixed to 32 because mul_unit is 32-bit)
- TAG_W, 5, width of destination-register tag carried alongside the operation

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  EX stage presents an M-extension op
- in_ready  out  1  unit can accept an op this cycle
- funct3  in  3  000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; 001/010/011 reserved
- rs1  in  XLEN  dividend / multiplicand
- rs2  in  XLEN  divisor / multiplier
- tag_in  in  TAG_W  destination register tag
- flush  in  1  synchronous kill of the in-flight op
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes the result
- result  out  XLEN  operation result
- tag_out  out  TAG_W  tag of the result
- busy  out  1  high in any state other than IDLE

Behaviour:
- **Reset.** When rst_n is low at an edge: state goes to IDLE; result, tag_out, out_valid and internal counters/registers go to 0. in_ready is forced 0 while rst_n is low.
- **States.**
  - IDLE: in_ready=1.
  - MUL: one cycle.
  - DIV: 32 cycles.
  - DONE: out_valid=1.
- **Accept.** An op is accepted when in_valid & in_ready & !flush. On accept, rs1, rs2, funct3 and tag_in are registered; later input changes are ignored.
- **MUL.** Accept at cycle T → state MUL at T+1. mul_unit is driven from the operand registers. Its output is registered into result at the end of T+1, giving out_valid=1 from T+2.
- **Reserved funct3.** Same path and latency as MUL, with result=0.
- **Divide special cases** (decided at accept, MUL-path latency, out_valid at T+2):
  - Divisor 0: quotient = 0xFFFFFFFF; remainder = rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- **Divide general case.**
  - Signed ops divide absolute values, then apply signs: quotient sign = sign(rs1)^sign(rs2); remainder sign = sign(rs1).
  - A 6-bit counter runs 0..31, one quotient bit per cycle, from T+1 to T+32.
  - On the edge that ends iteration 31, the sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU) is loaded into result and state goes to DONE. out_valid=1 from T+33.
- **DONE.**
  - result and tag_out are held stable until out_valid & out_ready.
  - On that edge, state goes to IDLE and out_valid drops. in_ready rises the following cycle; there is no same-cycle accept in DONE.
  - in_valid is ignored outside IDLE.
- **Flush.**
  - flush=1 at an edge sends any state to IDLE and clears out_valid and the counter. The killed result is never presented.
  - flush wins over a simultaneous accept.
  - flush in IDLE is a no-op.
- **Reset mid-operation.** Same as flush, and result/tag_out are also cleared.
- **Width rules.** MUL returns the low 32 bits of the product (the same for signed and unsigned). Divider working registers are 33-bit remainder plus 32-bit quotient. No wrap on the counter: it stops at 31.
- **busy** = (state != IDLE).

Test Plan:
1. MUL rs1=0x00010003, rs2=0x00000005, tag 7 → result=0x0005000F, tag_out=7, out_valid at T+2.
2. MUL rs1=rs2=0xFFFFFFFF → result=0x00000001 at T+2.
3. DIV rs1=0xFFFFFFF9 (-7), rs2=2 → 0xFFFFFFFD at T+33. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002.
4. DIVU 100/0 → 0xFFFFFFFF; REM 100/0 → 0x00000064. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0. All at T+2.
5. Hold out_ready=0 for 5 cycles in DONE while toggling rs1/in_valid → result, tag_out and out_valid stay stable and in_ready stays 0. Then out_ready=1 → IDLE, in_ready=1 one cycle later, next MUL accepted correctly.
6. Flush during DIV iteration 10 → out_valid never asserts and in_ready=1 the next cycle; a following MUL 6×7 returns 42. Repeat with rst_n low mid-DIV → result=0, tag_out=0, out_valid=0.

Source files
------------

// File: rtl/muldiv_seq.sv
// M-extension execute unit: registers operands into the combinational low-product
// multiplier and runs a radix-2 restoring divider, returning a tagged result.
module mul_unit #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] p
);
  assign p = a * b;
endmodule

// state  | meaning
// IDLE   | waiting for an op, in_ready=1
// MUL    | one cycle: multiply, reserved op, or divide special case
// DIV    | 32 restoring iterations, one quotient bit per cycle
// DONE   | out_valid=1, result held until out_ready
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_nx;

  logic [XLEN-1:0] op_a, op_b, quo, prod;
  logic [XLEN:0]   rem;
  logic [5:0]      cnt;
  logic [2:0]      fn;
  logic            neg_q, neg_r;

  logic            accept, is_div, sgn, div_zero, div_ovf, div_go;
  logic [XLEN-1:0] abs_a, abs_b, spec_val;
  logic [XLEN:0]   rem_sh, diff, rem_nx;
  logic [XLEN-1:0] quo_nx, q_fix, r_fix, div_res;
  logic            ge;

  assign in_ready  = rst_n && (state == S_IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  mul_unit #(.XLEN(XLEN)) u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // Divide special cases are resolved at accept and ride the one-cycle path.
  always_comb begin
    is_div   = funct3[2];
    sgn      = !funct3[0];
    div_zero = (rs2 == '0);
    div_ovf  = sgn && (rs1 == MIN_NEG) && (rs2 == ALL_ONES);
    div_go   = is_div && !div_zero && !div_ovf;
    abs_a    = (sgn && rs1[XLEN-1]) ? -rs1 : rs1;
    abs_b    = (sgn && rs2[XLEN-1]) ? -rs2 : rs2;
    if (div_zero)
      spec_val = funct3[1] ? rs1 : ALL_ONES;
    else
      spec_val = funct3[1] ? '0 : MIN_NEG;
  end

  // rem never exceeds the divisor, so rem[XLEN] stays 0; it only guards the compare.
  always_comb begin
    rem_sh  = {rem[XLEN-1:0], quo[XLEN-1]};
    diff    = rem_sh - {1'b0, op_b};
    ge      = rem[XLEN] | !diff[XLEN];
    rem_nx  = ge ? diff : rem_sh;
    quo_nx  = {quo[XLEN-2:0], ge};
    q_fix   = neg_q ? -quo_nx : quo_nx;
    r_fix   = neg_r ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
    div_res = fn[1] ? r_fix : q_fix;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) state_nx = div_go ? S_DIV : S_MUL;
        S_MUL:  state_nx = S_DONE;
        S_DIV:  if (cnt == 6'd31) state_nx = S_DONE;
        S_DONE: if (out_ready) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result  <= '0;
      tag_out <= '0;
      op_a    <= '0;
      op_b    <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      fn      <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            fn      <= funct3;
            tag_out <= tag_in;
            cnt     <= '0;
            rem     <= '0;
            neg_q   <= sgn && (rs1[XLEN-1] ^ rs2[XLEN-1]);
            neg_r   <= sgn && rs1[XLEN-1];
            if (div_go) begin
              op_a <= rs1;
              op_b <= abs_b;
              quo  <= abs_a;
            end else if (is_div) begin
              op_a <= spec_val;
            end else begin
              op_a <= rs1;
              op_b <= rs2;
            end
          end
        end
        S_MUL: begin
          if (fn == 3'b000)  result <= prod;
          else if (fn[2])    result <= op_a;
          else               result <= '0;
        end
        S_DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          if (cnt == 6'd31) result <= div_res;
          else              cnt    <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: latency, results, DONE hold, flush and reset.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, result;
  logic [4:0]  tag_in, tag_out;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .tag_in    (tag_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .tag_out   (tag_out),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Accept an op, measure edges from accept to out_valid, check, optionally hold, consume.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg,
                        input logic [31:0] exp, input int exp_lat, input int hold);
    int n;
    @(negedge clk);
    in_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; tag_in = tg;
    chk({nm, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; tag_in = 5'd0; funct3 = 3'b000;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    chk({nm, ".lat"}, n, exp_lat);
    chk({nm, ".result"}, result, exp);
    chk({nm, ".tag"}, {27'd0, tag_out}, {27'd0, tg});
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid; rs1 = $urandom;
      @(negedge clk);
      chk({nm, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({nm, ".hold_result"}, result, exp);
      chk({nm, ".hold_tag"}, {27'd0, tag_out}, {27'd0, tg});
      chk({nm, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, ".drop_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, ".ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    funct3 = 3'b000; rs1 = '0; rs2 = '0; tag_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.tag", {27'd0, tag_out}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    run_op("mul1",  3'b000, 32'h0001_0003, 32'h0000_0005, 5'd7,  32'h0005_000F, 1,  0);
    run_op("mul2",  3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0001, 1,  0);
    run_op("rsvd",  3'b010, 32'h1234_5678, 32'h0000_0003, 5'd4,  32'h0000_0000, 1,  0);
    run_op("div",   3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD, 32, 0);
    run_op("rem",   3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 32, 0);
    run_op("divu",  3'b101, 32'd100,       32'd7,         5'd11, 32'h0000_000E, 32, 0);
    run_op("remu",  3'b111, 32'd100,       32'd7,         5'd12, 32'h0000_0002, 32, 0);
    run_op("divu0", 3'b101, 32'd100,       32'd0,         5'd13, 32'hFFFF_FFFF, 1,  0);
    run_op("rem0",  3'b110, 32'd100,       32'd0,         5'd14, 32'h0000_0064, 1,  0);
    run_op("ovfq",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1,  0);
    run_op("ovfr",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1,  0);
    run_op("hold",  3'b000, 32'd9,         32'd11,        5'd17, 32'd99,        1,  5);
    run_op("after", 3'b000, 32'd3,         32'd5,         5'd18, 32'd15,        1,  0);

    // flush beats a simultaneous accept
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flushacc.busy", {31'd0, busy}, 32'd0);

    // flush during divide iteration 10
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; tag_in = 5'd21;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("flush.busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush.never_valid", seen, 0);
    run_op("mul67", 3'b000, 32'd6, 32'd7, 5'd22, 32'd42, 1, 0);

    // reset during divide
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; tag_in = 5'd23;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid.in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rstmid.result", result, 32'd0);
    chk("rstmid.tag", {27'd0, tag_out}, 32'd0);
    chk("rstmid.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rstmid.never_valid", seen, 0);
    run_op("postrst", 3'b111, 32'hFFFF_FFF9, 32'd2, 5'd24, 32'h0000_0001, 32, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
